// File: rtl/wb_gpio_master_pkg.sv
// Shared types and GPIO register map for the Wishbone GPIO command master and its benches.
package wb_gpio_master_pkg;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'd0,
        OP_READ    = 2'd1,
        OP_RMW_SET = 2'd2,
        OP_RMW_CLR = 2'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_GAP,
        ST_WR,
        ST_RESP
    } state_e;

    // GPIO controller register offsets (byte addresses on the slave port)
    localparam logic [5:0] GPIO_REG_DIN    = 6'h00;
    localparam logic [5:0] GPIO_REG_DOUT   = 6'h04;
    localparam logic [5:0] GPIO_REG_DIR    = 6'h08;
    localparam logic [5:0] GPIO_REG_IRQ_EN = 6'h0C;

    function automatic logic is_rmw(input cmd_op_e op);
        return (op == OP_RMW_SET) || (op == OP_RMW_CLR);
    endfunction

endpackage

// File: rtl/wb_gpio_master_if.sv
// Wishbone classic bus between the command master and the GPIO register slave.
interface wb_gpio_master_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic                    wb_cyc_o;
    logic                    wb_stb_o;
    logic                    wb_we_o;
    logic [ADDR_WIDTH-1:0]   wb_adr_o;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic [DATA_WIDTH/8-1:0] wb_sel_o;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic                    wb_ack_i;
    logic                    wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_master_timeout.sv
// Per-phase stall counter: flags the LIMIT-th consecutive enabled cycle.
// Latency: expired is combinational from the count and enable.
// Backpressure: none; clear has priority over enable.
module wb_master_timeout #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [CW-1:0] cnt_q;

    assign expired = enable && (cnt_q == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/wb_gpio_master.sv
// Wishbone classic master issuing WRITE/READ/RMW_SET/RMW_CLR commands to the GPIO register slave.
// Latency: 1-cycle ack gives rsp_valid at accept+2 (RMW accept+4), plus any slave wait states.
// Backpressure: one command in flight, response held until rsp_ready; WB_MASTER_TIMEOUT_EN bounds each phase.
module wb_gpio_master
    import wb_gpio_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_sel,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    busy,
    wb_gpio_master_if.master        wb
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    state_e                 state_q, state_d;
    cmd_op_e                op_q;
    logic [ADDR_WIDTH-1:0]  adr_q;
    logic [DATA_WIDTH-1:0]  dat_q;
    logic [SEL_WIDTH-1:0]   sel_q;
    logic [DATA_WIDTH-1:0]  rd_q;
    logic [DATA_WIDTH-1:0]  rsp_data_q;
    logic                   rsp_err_q;
    logic                   rsp_timeout_q;
    logic                   phase_active;
    logic                   timeout_hit;
    logic [DATA_WIDTH-1:0]  merged_dat;
    cmd_op_e                cmd_op_cast;

    assign cmd_op_cast  = cmd_op_e'(cmd_op);
    assign phase_active = (state_q == ST_RD) || (state_q == ST_WR);
    // dat_q still carries the RMW mask while the read phase is open
    assign merged_dat   = (op_q == OP_RMW_SET) ? (wb.wb_dat_i | dat_q)
                                               : (wb.wb_dat_i & ~dat_q);

`ifdef WB_MASTER_TIMEOUT_EN
    wb_master_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clear   (!phase_active),
        .enable  (phase_active && !wb.wb_ack_i && !wb.wb_err_i),
        .expired (timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // err outranks ack; timeout only fires on a cycle with neither
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (cmd_valid) state_d = (cmd_op_cast == OP_WRITE) ? ST_WR : ST_RD;
            ST_RD: begin
                if (wb.wb_err_i || timeout_hit) state_d = ST_RESP;
                else if (wb.wb_ack_i)           state_d = (op_q == OP_READ) ? ST_RESP : ST_WR_GAP;
            end
            ST_WR_GAP: state_d = ST_WR;
            ST_WR:     if (wb.wb_ack_i || wb.wb_err_i || timeout_hit) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        rsp_valid   = 1'b0;
        wb.wb_cyc_o = 1'b0;
        wb.wb_stb_o = 1'b0;
        wb.wb_we_o  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_RD: begin
                wb.wb_cyc_o = 1'b1;
                wb.wb_stb_o = 1'b1;
            end
            ST_WR: begin
                wb.wb_cyc_o = 1'b1;
                wb.wb_stb_o = 1'b1;
                wb.wb_we_o  = 1'b1;
            end
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            op_q          <= OP_WRITE;
            adr_q         <= '0;
            dat_q         <= '0;
            sel_q         <= '0;
            rd_q          <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op_cast;
                        adr_q <= cmd_addr;
                        dat_q <= cmd_wdata;
                        sel_q <= is_rmw(cmd_op_cast) ? {SEL_WIDTH{1'b1}} : cmd_sel;
                    end
                end
                ST_RD: begin
                    if (wb.wb_err_i || timeout_hit) begin
                        rsp_data_q    <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= timeout_hit;
                    end else if (wb.wb_ack_i) begin
                        rd_q          <= wb.wb_dat_i;
                        dat_q         <= merged_dat;
                        rsp_data_q    <= wb.wb_dat_i;
                        rsp_err_q     <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                    end
                end
                ST_WR: begin
                    if (wb.wb_err_i || timeout_hit) begin
                        rsp_data_q    <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= timeout_hit;
                    end else if (wb.wb_ack_i) begin
                        rsp_data_q    <= (op_q == OP_WRITE) ? '0 : rd_q;
                        rsp_err_q     <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb.wb_adr_o   = adr_q;
    assign wb.wb_dat_o   = dat_q;
    assign wb.wb_sel_o   = sel_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_timeout   = rsp_timeout_q;
endmodule

// File: tb/tb_wb_gpio_master.sv
// Directed and randomized bench for wb_gpio_master against a register-map reference model.
module tb_wb_gpio_master;
    import wb_gpio_master_pkg::*;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    typedef struct {
        int waits;
        bit err;
    } rsp_cfg_t;

    typedef struct {
        bit          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
        int          ncyc;
        bit          stable;
        bit          done;
    } phase_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_sel = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          busy;

    always #5 clk = ~clk;

    wb_gpio_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

    wb_gpio_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_sel     (cmd_sel),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .wb          (wb)
    );

    rsp_cfg_t      sq[$];
    phase_t        plog[$];
    logic [DW-1:0] slave_mem [64];
    logic [DW-1:0] ref_mem [64];
    int            n_checks = 0;
    int            n_errs = 0;

    // Slave responder: per-phase wait states / error taken from sq, every phase logged to plog
    initial begin
        phase_t   cur;
        rsp_cfg_t rc;
        bit       in_ph;
        int       cur_wait;
        bit       cur_err;
        in_ph = 0;
        cur_wait = 0;
        cur_err = 0;
        wb.wb_ack_i = 1'b0;
        wb.wb_err_i = 1'b0;
        wb.wb_dat_i = '0;
        forever begin
            @(negedge clk);
            wb.wb_ack_i = 1'b0;
            wb.wb_err_i = 1'b0;
            wb.wb_dat_i = $urandom;
            if (wb.wb_stb_o === 1'b1) begin
                if (!in_ph) begin
                    in_ph = 1;
                    cur = '{we: wb.wb_we_o, adr: wb.wb_adr_o, dat: wb.wb_dat_o, sel: wb.wb_sel_o,
                            ncyc: 0, stable: 1'b1, done: 1'b0};
                    if (sq.size() > 0) begin
                        rc = sq.pop_front();
                        cur_wait = rc.waits;
                        cur_err = rc.err;
                    end else begin
                        cur_wait = 1 << 30;
                        cur_err = 0;
                    end
                end else if (wb.wb_we_o !== cur.we || wb.wb_adr_o !== cur.adr ||
                             wb.wb_dat_o !== cur.dat || wb.wb_sel_o !== cur.sel) begin
                    cur.stable = 1'b0;
                end
                if (wb.wb_cyc_o !== 1'b1) cur.stable = 1'b0;
                cur.ncyc++;
                if (cur.ncyc > cur_wait) begin
                    if (cur_err) begin
                        wb.wb_err_i = 1'b1;
                        wb.wb_ack_i = 1'($urandom_range(0, 1));
                    end else begin
                        wb.wb_ack_i = 1'b1;
                        if (cur.we) begin
                            for (int b = 0; b < SW; b++)
                                if (cur.sel[b]) slave_mem[cur.adr][8*b +: 8] = cur.dat[8*b +: 8];
                        end else begin
                            wb.wb_dat_i = slave_mem[cur.adr];
                        end
                    end
                    cur.done = 1'b1;
                    plog.push_back(cur);
                    in_ph = 0;
                end
            end else if (in_ph) begin
                plog.push_back(cur);
                in_ph = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One command end to end; w<0 means the slave never answers that phase
    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [SW-1:0] sl, input int w0, input bit e0,
                           input int w1, input bit e1, input int hold);
        phase_t        exp_ph[$];
        phase_t        got;
        logic [DW-1:0] exp_data, v, nv;
        bit            exp_err, exp_to;
        int            exp_lat, lat, c0, c1;
        exp_data = '0;
        exp_err = 0;
        exp_to = 0;
        c0 = (w0 < 0) ? TO : w0 + 1;
        c1 = (w1 < 0) ? TO : w1 + 1;
        if (w0 >= 0) sq.push_back('{w0, e0});
        exp_lat = 1 + c0;
        if (op == OP_WRITE) begin
            exp_ph.push_back('{we: 1'b1, adr: a, dat: wd, sel: sl, ncyc: c0, stable: 1'b1, done: (w0 >= 0)});
            if (w0 < 0) begin
                exp_err = 1; exp_to = 1;
            end else if (e0) begin
                exp_err = 1;
            end else begin
                for (int b = 0; b < SW; b++) if (sl[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
            end
        end else begin
            exp_ph.push_back('{we: 1'b0, adr: a, dat: '0, sel: (op == OP_READ) ? sl : {SW{1'b1}},
                               ncyc: c0, stable: 1'b1, done: (w0 >= 0)});
            if (w0 < 0) begin
                exp_err = 1; exp_to = 1;
            end else if (e0) begin
                exp_err = 1;
            end else if (op == OP_READ) begin
                exp_data = ref_mem[a];
            end else begin
                v = ref_mem[a];
                nv = (op == OP_RMW_SET) ? (v | wd) : (v & ~wd);
                if (w1 >= 0) sq.push_back('{w1, e1});
                exp_ph.push_back('{we: 1'b1, adr: a, dat: nv, sel: {SW{1'b1}}, ncyc: c1,
                                   stable: 1'b1, done: (w1 >= 0)});
                exp_lat = 1 + c0 + 1 + c1;
                if (w1 < 0) begin
                    exp_err = 1; exp_to = 1;
                end else if (e1) begin
                    exp_err = 1;
                end else begin
                    ref_mem[a] = nv;
                    exp_data = v;
                end
            end
        end

        @(negedge clk);
        check("idle_cmd_ready", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_sel = sl;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = AW'($urandom);
        cmd_wdata = $urandom; cmd_sel = SW'($urandom);
        lat = 1;
        check("busy_after_accept", 64'({cmd_ready, busy}), 64'(2'b01));
        while (rsp_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("rsp_latency", 64'(lat), 64'(exp_lat));
        check("rsp_fields", 64'({rsp_valid, cmd_ready, rsp_err, rsp_timeout, rsp_data}),
              64'({1'b1, 1'b0, exp_err, exp_to, exp_data}));
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            @(negedge clk);
            check("rsp_hold", 64'({rsp_valid, cmd_ready, rsp_err, rsp_timeout, rsp_data}),
                  64'({1'b1, 1'b0, exp_err, exp_to, exp_data}));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("after_handshake", 64'({rsp_valid, cmd_ready, busy, wb.wb_cyc_o}), 64'(4'b0100));
        check("phase_count", 64'(plog.size()), 64'(exp_ph.size()));
        foreach (exp_ph[i]) begin
            if (plog.size() > 0) begin
                got = plog.pop_front();
                check("ph_we_adr_sel", 64'({got.we, got.adr, got.sel}),
                      64'({exp_ph[i].we, exp_ph[i].adr, exp_ph[i].sel}));
                check("ph_wdat", 64'(got.we ? got.dat : 32'd0), 64'(exp_ph[i].we ? exp_ph[i].dat : 32'd0));
                check("ph_stb_cycles", 64'(got.ncyc), 64'(exp_ph[i].ncyc));
                check("ph_stable_done", 64'({got.stable, got.done}), 64'({1'b1, exp_ph[i].done}));
            end
        end
        sq.delete();
        plog.delete();
    endtask

    logic [1:0]    r_op;
    logic [AW-1:0] r_a;
    logic [DW-1:0] r_wd;
    logic [SW-1:0] r_sl;
    int            r_w0, r_w1, r_hold;
    bit            r_e0, r_e1;
    int            guard;

    initial begin
        for (int i = 0; i < 64; i++) slave_mem[i] = $urandom;
        slave_mem[GPIO_REG_DIN] = 32'h0012_3456;
        slave_mem[GPIO_REG_DIR] = 32'h0000_0003;
        ref_mem = slave_mem;

        @(negedge clk);
        @(negedge clk);
        check("reset_bus", 64'({wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_adr_o, wb.wb_sel_o}), 64'(0));
        check("reset_wdat", 64'(wb.wb_dat_o), 64'(0));
        check("reset_rsp", 64'({rsp_valid, rsp_err, rsp_timeout, rsp_data}), 64'(0));
        check("reset_ready_busy", 64'({cmd_ready, busy}), 64'(2'b10));
        rst = 1'b0;

        run_cmd(OP_WRITE,   GPIO_REG_DOUT, 32'hA5A5_0F0F, 4'hF, 0, 0, 0, 0, 0);
        run_cmd(OP_READ,    GPIO_REG_DIN,  32'h0,         4'hF, 3, 0, 0, 0, 0);
        run_cmd(OP_RMW_SET, GPIO_REG_DIR,  32'h0000_00F0, 4'h3, 0, 0, 0, 0, 0);
        run_cmd(OP_RMW_CLR, GPIO_REG_DIR,  32'h0000_0001, 4'h1, 1, 1, 0, 0, 0);
        run_cmd(OP_WRITE,   GPIO_REG_DOUT, 32'h1234_5678, 4'h5, 2, 0, 0, 0, 5);
        run_cmd(OP_WRITE,   GPIO_REG_IRQ_EN, 32'hFFFF_0000, 4'hC, 0, 1, 0, 0, 1);
        run_cmd(OP_RMW_CLR, GPIO_REG_DIR,  32'h0000_0030, 4'h0, 2, 0, 1, 0, 2);

        // reset while the read phase is still waiting on the slave
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr = 6'h10;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rst_rd_stb_open", 64'({wb.wb_cyc_o, wb.wb_stb_o}), 64'(2'b11));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_rd", 64'({wb.wb_cyc_o, wb.wb_stb_o, rsp_valid, busy, cmd_ready}), 64'(5'b00001));
        rst = 1'b0;
        @(negedge clk);
        sq.delete();
        plog.delete();

        // reset while a response is pending discards it
        sq.push_back('{0, 0});
        cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_addr = GPIO_REG_IRQ_EN;
        cmd_wdata = 32'h0BAD_F00D; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        ref_mem[GPIO_REG_IRQ_EN] = 32'h0BAD_F00D;
        guard = 0;
        while (rsp_valid !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("rst_resp_pending", 64'(rsp_valid), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        check("rst_resp_dropped", 64'({rsp_valid, busy, cmd_ready, rsp_data}), 64'({3'b001, 32'd0}));
        rst = 1'b0;
        @(negedge clk);
        sq.delete();
        plog.delete();

        for (int k = 0; k < 40; k++) begin
            r_op   = 2'($urandom);
            r_a    = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'(4 * $urandom_range(0, 3));
            r_wd   = $urandom;
            r_sl   = SW'($urandom);
            r_w0   = $urandom_range(0, 3);
            r_e0   = ($urandom_range(0, 7) == 0);
            r_w1   = $urandom_range(0, 3);
            r_e1   = ($urandom_range(0, 7) == 0);
            r_hold = $urandom_range(0, 3);
            run_cmd(r_op, r_a, r_wd, r_sl, r_w0, r_e0, r_w1, r_e1, r_hold);
        end

`ifdef WB_MASTER_TIMEOUT_EN
        run_cmd(OP_READ,    GPIO_REG_DIN,  32'h0,         4'hF, -1, 0, 0, 0, 2);
        run_cmd(OP_RMW_SET, GPIO_REG_DOUT, 32'h0000_0F00, 4'hF, 1, 0, -1, 0, 0);
        run_cmd(OP_RMW_CLR, GPIO_REG_DIR,  32'h0000_0001, 4'hF, -1, 0, 0, 0, 0);
`endif

        for (int i = 0; i < 64; i++) check("final_reg_contents", 64'(slave_mem[i]), 64'(ref_mem[i]));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/wb_gpio_master.md
Name: wb_gpio_master

Overview:
- Wishbone classic single-cycle master that drives the GPIO controller's register slave port.
- Accepts register commands from firmware-side or test logic over a valid/ready interface: WRITE, READ, RMW_SET, RMW_CLR.
- Issues one bus cycle per command, or a read then a write for RMW, and returns a response over a valid/ready interface.
- Sits between an internal command source and the GPIO block's wb_* slave pins.

Parameters:
- ADDR_WIDTH, 6, Wishbone address width; matches the GPIO slave address port.
- DATA_WIDTH, 32, Wishbone data width.
- TIMEOUT_CYCLES, 255, maximum stb cycles per phase before abort; used only with the timeout feature.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accept.
- cmd_op  in  2  0=WRITE, 1=READ, 2=RMW_SET, 3=RMW_CLR.
- cmd_addr  in  ADDR_WIDTH  register address.
- cmd_wdata  in  DATA_WIDTH  write data (WRITE) or bit mask (RMW).
- cmd_sel  in  DATA_WIDTH/8  byte select for WRITE/READ.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_WIDTH  read data (READ/RMW: the value read); 0 for WRITE or on error.
- rsp_err  out  1  bus error or timeout.
- rsp_timeout  out  1  timeout abort.
- busy  out  1  state != IDLE.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  ADDR_WIDTH  address.
- wb_dat_o  out  DATA_WIDTH  write data.
- wb_sel_o  out  DATA_WIDTH/8  byte select.
- wb_dat_i  in  DATA_WIDTH  read data.
- wb_ack_i  in  1  slave acknowledge.
- wb_err_i  in  1  slave error.

Behaviour:
- Reset values: all outputs 0, cmd_ready=1, state IDLE.
- Reset mid-operation: cyc/stb drop at the reset edge and any pending response is discarded.
- States: IDLE, RD, WR_GAP, WR, RESP.
- IDLE
  - cmd_ready=1.
  - Accept on cmd_valid&&cmd_ready at edge N; command fields are latched.
  - WRITE -> WR; READ, RMW_* -> RD.
  - wb_cyc_o=wb_stb_o=1 from cycle N+1.
- Bus phase (RD/WR):
  - cyc, stb, we, adr, dat and sel are registered and held stable until wb_ack_i or wb_err_i is sampled high.
  - At that edge cyc/stb are cleared.
  - Zero-wait-state slave: ack seen at the first stb cycle → phase lasts 1 cycle.
- Simultaneous ack and err: err wins.
- RD outcomes:
  - ack on READ → RESP with rsp_data=wb_dat_i.
  - ack on RMW → WR_GAP with the read value latched.
  - err → RESP with rsp_err=1, rsp_data=0; the write phase is skipped.
- WR_GAP:
  - One cycle with cyc=stb=0, then WR.
  - WR data: RMW_SET = rd | mask; RMW_CLR = rd & ~mask.
  - wb_sel_o is all ones for RMW phases and cmd_sel otherwise.
- WR outcomes: ack or err → RESP.
  - rsp_data = read value for RMW, 0 for WRITE.
  - rsp_err = err.
- RESP:
  - rsp_valid=1 from the cycle after the terminating edge.
  - rsp_valid and the response fields are held until rsp_ready.
  - At that edge → IDLE with cmd_ready=1 the following cycle.
  - No command overlap: at most one outstanding command.
- Latency:
  - WRITE/READ with a 1-cycle ack: accept N, stb N+1, rsp_valid N+2.
  - RMW: rsp_valid N+4.
- cmd_* inputs are ignored outside IDLE.

Optional Feature:
- WB_MASTER_TIMEOUT_EN defined:
  - A per-phase counter clears on entering RD/WR and increments each stb cycle without ack/err.
  - At the TIMEOUT_CYCLES-th such cycle, cyc/stb drop and the state goes to RESP with rsp_err=1, rsp_timeout=1, rsp_data=0.
  - An RMW that times out in RD skips WR.
- Undefined: no counter; the master waits indefinitely; rsp_timeout tied 0.

Decomposition:
- Package wb_gpio_master_pkg:
  - cmd_op_e enum (WRITE, READ, RMW_SET, RMW_CLR).
  - state_e enum.
  - GPIO register offset constants, shared with benches.
- Sub-module wb_master_timeout: counter with clear, enable and expired outputs; instantiated only under WB_MASTER_TIMEOUT_EN.

Test Plan:
- WRITE addr 0x04, data 0xA5A5_0F0F, sel 0xF, slave acks on first stb → one bus cycle, we=1, dat_o=0xA5A5_0F0F; rsp_valid 2 cycles after accept, rsp_err=0, rsp_data=0.
- READ addr 0x00, slave returns 0x0012_3456 after 3 wait states → stb held 4 cycles with stable adr; rsp_data=0x0012_3456.
- RMW_SET addr 0x08, mask 0x0000_00F0, read returns 0x0000_0003 → two cycles separated by one idle cycle; write dat_o=0x0000_00F3, sel=0xF; rsp_data=0x0000_0003.
- RMW_CLR with wb_err_i on the read phase → no write cycle issued; rsp_err=1, rsp_data=0.
- Hold rsp_ready=0 for 5 cycles → rsp fields stable, cmd_ready=0; a new cmd_valid is not accepted until after the rsp_ready edge. Assert wb_rst_i mid-RD → cyc/stb=0 and rsp_valid=0 the next cycle.
- (WB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8) slave never acks → stb high exactly 8 cycles; rsp_err=1, rsp_timeout=1.
